// File: rtl/execute_forwarding_multi.sv
// execute_forwarding_multi
// Resolves execute-stage source operands, SPR and PSR against the current
// writeback and a short registered history of recent writebacks.
// Optional FRCR forwarding is enabled by defining
// EXECUTE_FORWARDING_MULTI_FRCR_EN.
`timescale 1ns/1ps

`ifndef SYSREG_PSR
`define SYSREG_PSR 5'h01
`endif
`ifndef SYSREG_SPR
`define SYSREG_SPR 5'h08
`endif
`ifndef SYSREG_FRCLR
`define SYSREG_FRCLR 5'h0C
`endif
`ifndef SYSREG_FRCHR
`define SYSREG_FRCHR 5'h0D
`endif
`ifndef SYSREG_FRCR2FRCXR
`define SYSREG_FRCR2FRCXR 5'h0E
`endif

module execute_forwarding_multi #(
    parameter int P_DEPTH = 2,
    parameter int P_NSRC  = 2
) (
    input  logic                  iCLOCK,
    input  logic                  iRESET,
    input  logic                  iFLUSH,
    input  logic                  iHOLD,
    input  logic                  iWB_GR_VALID,
    input  logic [4:0]            iWB_GR_DEST,
    input  logic                  iWB_GR_DEST_SYSREG,
    input  logic [31:0]           iWB_GR_DATA,
    input  logic                  iWB_SPR_VALID,
    input  logic [31:0]           iWB_SPR_DATA,
`ifdef EXECUTE_FORWARDING_MULTI_FRCR_EN
    input  logic                  iWB_FRCR_VALID,
    input  logic [63:0]           iWB_FRCR_DATA,
`endif
    input  logic [P_NSRC-1:0]     iSRC_IMM,
    input  logic [P_NSRC-1:0]     iSRC_SYSREG,
    input  logic [5*P_NSRC-1:0]   iSRC_POINTER,
    input  logic [32*P_NSRC-1:0]  iSRC_DATA,
    input  logic [31:0]           iSRC_SPR,
    input  logic [31:0]           iSRC_PSR,
    output logic [32*P_NSRC-1:0]  oSRC_DATA,
    output logic [P_NSRC-1:0]     oSRC_HIT,
    output logic [31:0]           oSPR,
    output logic [31:0]           oPSR
);

    typedef struct packed {
        logic        gr_valid;
        logic [4:0]  dest;
        logic        sysreg;
        logic [31:0] gr_data;
        logic        spr_valid;
        logic [31:0] spr_data;
`ifdef EXECUTE_FORWARDING_MULTI_FRCR_EN
        logic        frcr_valid;
        logic [63:0] frcr_data;
`endif
    } level_t;

    // hist[0] is the newest registered writeback
    level_t hist [P_DEPTH];
    // levels[0] is the live writeback, levels[k+1] mirrors hist[k]
    level_t levels [P_DEPTH+1];
    logic   shift_en;

    // Returns {hit, value} for one source lookup against one level
    function automatic logic [32:0] match_level(
        input level_t     lv,
        input logic       src_sysreg,
        input logic [4:0] ptr
    );
        logic [32:0] res;
        res = '0;
        if (!src_sysreg) begin
            if (lv.gr_valid && !lv.sysreg && (lv.dest == ptr))
                res = {1'b1, lv.gr_data};
        end else if (ptr == `SYSREG_SPR) begin
            // A dedicated SPR write beats a GR write to SPR in the same level
            if (lv.spr_valid)
                res = {1'b1, lv.spr_data};
            else if (lv.gr_valid && lv.sysreg && (lv.dest == `SYSREG_SPR))
                res = {1'b1, lv.gr_data};
        end else begin
`ifdef EXECUTE_FORWARDING_MULTI_FRCR_EN
            if ((ptr == `SYSREG_FRCLR) && lv.frcr_valid && (lv.dest == `SYSREG_FRCR2FRCXR))
                res = {1'b1, lv.frcr_data[31:0]};
            else if ((ptr == `SYSREG_FRCHR) && lv.frcr_valid && (lv.dest == `SYSREG_FRCR2FRCXR))
                res = {1'b1, lv.frcr_data[63:32]};
            else if (lv.gr_valid && lv.sysreg && (lv.dest == ptr))
                res = {1'b1, lv.gr_data};
`else
            if (lv.gr_valid && lv.sysreg && (lv.dest == ptr))
                res = {1'b1, lv.gr_data};
`endif
        end
        return res;
    endfunction

    // Any real writeback forces the history to advance even while held
`ifdef EXECUTE_FORWARDING_MULTI_FRCR_EN
    assign shift_en = !iHOLD || iWB_GR_VALID || iWB_SPR_VALID || iWB_FRCR_VALID;
`else
    assign shift_en = !iHOLD || iWB_GR_VALID || iWB_SPR_VALID;
`endif

    // Assemble the lookup levels, newest (live writeback) first
    always_comb begin
        for (int i = 0; i <= P_DEPTH; i++)
            levels[i] = '0;
        levels[0].gr_valid  = iWB_GR_VALID;
        levels[0].dest      = iWB_GR_DEST;
        levels[0].sysreg    = iWB_GR_DEST_SYSREG;
        levels[0].gr_data   = iWB_GR_DATA;
        levels[0].spr_valid = iWB_SPR_VALID;
        levels[0].spr_data  = iWB_SPR_DATA;
`ifdef EXECUTE_FORWARDING_MULTI_FRCR_EN
        levels[0].frcr_valid = iWB_FRCR_VALID;
        levels[0].frcr_data  = iWB_FRCR_DATA;
`endif
        for (int i = 0; i < P_DEPTH; i++)
            levels[i+1] = hist[i];
    end

    // History shift register: reset clears everything, flush drops validity
    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            for (int i = 0; i < P_DEPTH; i++)
                hist[i] <= '0;
        end else if (iFLUSH) begin
            for (int i = 0; i < P_DEPTH; i++) begin
                hist[i].gr_valid  <= 1'b0;
                hist[i].spr_valid <= 1'b0;
`ifdef EXECUTE_FORWARDING_MULTI_FRCR_EN
                hist[i].frcr_valid <= 1'b0;
`endif
            end
        end else if (shift_en) begin
            hist[0] <= levels[0];
            for (int i = 1; i < P_DEPTH; i++)
                hist[i] <= hist[i-1];
        end
    end

    // Per-operand resolution; scanning oldest to newest lets the newest match win
    always_comb begin
        logic [32:0] res;
        res       = '0;
        oSRC_DATA = iSRC_DATA;
        oSRC_HIT  = '0;
        for (int k = 0; k < P_NSRC; k++) begin
            if (!iRESET && !iSRC_IMM[k]) begin
                for (int l = P_DEPTH; l >= 0; l--) begin
                    res = match_level(levels[l], iSRC_SYSREG[k], iSRC_POINTER[k*5 +: 5]);
                    if (res[32]) begin
                        oSRC_HIT[k]          = 1'b1;
                        oSRC_DATA[k*32 +: 32] = res[31:0];
                    end
                end
            end
        end
    end

    // Stack pointer and PSR use the same newest-wins search
    always_comb begin
        logic [32:0] res_spr;
        logic [32:0] res_psr;
        res_spr = '0;
        res_psr = '0;
        oSPR    = iSRC_SPR;
        oPSR    = iSRC_PSR;
        if (!iRESET) begin
            for (int l = P_DEPTH; l >= 0; l--) begin
                res_spr = match_level(levels[l], 1'b1, `SYSREG_SPR);
                res_psr = match_level(levels[l], 1'b1, `SYSREG_PSR);
                if (res_spr[32])
                    oSPR = res_spr[31:0];
                if (res_psr[32])
                    oPSR = res_psr[31:0];
            end
        end
    end

endmodule

// File: tb/tb_execute_forwarding_multi.sv
// tb_execute_forwarding_multi
// Directed scenarios plus randomized traffic against a queue-based model of
// the writeback history for execute_forwarding_multi.
`timescale 1ns/1ps

`ifndef SYSREG_PSR
`define SYSREG_PSR 5'h01
`endif
`ifndef SYSREG_SPR
`define SYSREG_SPR 5'h08
`endif
`ifndef SYSREG_FRCLR
`define SYSREG_FRCLR 5'h0C
`endif
`ifndef SYSREG_FRCHR
`define SYSREG_FRCHR 5'h0D
`endif
`ifndef SYSREG_FRCR2FRCXR
`define SYSREG_FRCR2FRCXR 5'h0E
`endif

module tb_execute_forwarding_multi;

    localparam int P_DEPTH = 2;
    localparam int P_NSRC  = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 flush;
    logic                 hold;
    logic                 wb_gr_valid;
    logic [4:0]           wb_gr_dest;
    logic                 wb_gr_dest_sysreg;
    logic [31:0]          wb_gr_data;
    logic                 wb_spr_valid;
    logic [31:0]          wb_spr_data;
    logic                 wb_frcr_valid;
    logic [63:0]          wb_frcr_data;
    logic [P_NSRC-1:0]    src_imm;
    logic [P_NSRC-1:0]    src_sysreg;
    logic [5*P_NSRC-1:0]  src_pointer;
    logic [32*P_NSRC-1:0] src_data;
    logic [31:0]          src_spr;
    logic [31:0]          src_psr;
    logic [32*P_NSRC-1:0] out_src_data;
    logic [P_NSRC-1:0]    out_src_hit;
    logic [31:0]          out_spr;
    logic [31:0]          out_psr;

    int total_checks = 0;
    int bad_checks   = 0;

    typedef struct {
        logic        gr_valid;
        logic [4:0]  dest;
        logic        sysreg;
        logic [31:0] gr_data;
        logic        spr_valid;
        logic [31:0] spr_data;
        logic        frcr_valid;
        logic [63:0] frcr_data;
    } wb_rec_t;

    // Most recent registered writebacks, index 0 newest, at most P_DEPTH long
    wb_rec_t model_q[$];

    execute_forwarding_multi #(.P_DEPTH(P_DEPTH), .P_NSRC(P_NSRC)) dut (
        .iCLOCK             (clk),
        .iRESET             (rst),
        .iFLUSH             (flush),
        .iHOLD              (hold),
        .iWB_GR_VALID       (wb_gr_valid),
        .iWB_GR_DEST        (wb_gr_dest),
        .iWB_GR_DEST_SYSREG (wb_gr_dest_sysreg),
        .iWB_GR_DATA        (wb_gr_data),
        .iWB_SPR_VALID      (wb_spr_valid),
        .iWB_SPR_DATA       (wb_spr_data),
`ifdef EXECUTE_FORWARDING_MULTI_FRCR_EN
        .iWB_FRCR_VALID     (wb_frcr_valid),
        .iWB_FRCR_DATA      (wb_frcr_data),
`endif
        .iSRC_IMM           (src_imm),
        .iSRC_SYSREG        (src_sysreg),
        .iSRC_POINTER       (src_pointer),
        .iSRC_DATA          (src_data),
        .iSRC_SPR           (src_spr),
        .iSRC_PSR           (src_psr),
        .oSRC_DATA          (out_src_data),
        .oSRC_HIT           (out_src_hit),
        .oSPR               (out_spr),
        .oPSR               (out_psr)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total_checks++;
        if (observed !== expected) begin
            bad_checks++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic wb_rec_t cur_rec();
        wb_rec_t r;
        r.gr_valid   = wb_gr_valid;
        r.dest       = wb_gr_dest;
        r.sysreg     = wb_gr_dest_sysreg;
        r.gr_data    = wb_gr_data;
        r.spr_valid  = wb_spr_valid;
        r.spr_data   = wb_spr_data;
        r.frcr_valid = wb_frcr_valid;
        r.frcr_data  = wb_frcr_data;
        return r;
    endfunction

    // What a single writeback record supplies to a lookup, as {hit, value}
    function automatic logic [32:0] ref_level(input wb_rec_t r, input logic sys, input logic [4:0] ptr);
        if (!sys)
            return (r.gr_valid && !r.sysreg && r.dest == ptr) ? {1'b1, r.gr_data} : 33'd0;
        if (ptr == `SYSREG_SPR) begin
            if (r.spr_valid)
                return {1'b1, r.spr_data};
            return (r.gr_valid && r.sysreg && r.dest == `SYSREG_SPR) ? {1'b1, r.gr_data} : 33'd0;
        end
`ifdef EXECUTE_FORWARDING_MULTI_FRCR_EN
        if (ptr == `SYSREG_FRCLR && r.frcr_valid && r.dest == `SYSREG_FRCR2FRCXR)
            return {1'b1, r.frcr_data[31:0]};
        if (ptr == `SYSREG_FRCHR && r.frcr_valid && r.dest == `SYSREG_FRCR2FRCXR)
            return {1'b1, r.frcr_data[63:32]};
`endif
        return (r.gr_valid && r.sysreg && r.dest == ptr) ? {1'b1, r.gr_data} : 33'd0;
    endfunction

    // First match when walking from the live writeback back through history
    function automatic logic [32:0] ref_resolve(input logic sys, input logic [4:0] ptr);
        logic [32:0] r;
        r = ref_level(cur_rec(), sys, ptr);
        if (r[32])
            return r;
        foreach (model_q[i]) begin
            r = ref_level(model_q[i], sys, ptr);
            if (r[32])
                return r;
        end
        return 33'd0;
    endfunction

    // Clock edge: DUT and model both advance from the same stable inputs
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            model_q.delete();
        end else if (flush) begin
            foreach (model_q[i]) begin
                model_q[i].gr_valid   = 1'b0;
                model_q[i].spr_valid  = 1'b0;
                model_q[i].frcr_valid = 1'b0;
            end
        end else if (!hold || wb_gr_valid || wb_spr_valid || wb_frcr_valid) begin
            model_q.push_front(cur_rec());
            if (model_q.size() > P_DEPTH)
                void'(model_q.pop_back());
        end
        #1;
    endtask

    task automatic idle_inputs();
        flush             = 1'b0;
        hold              = 1'b0;
        wb_gr_valid       = 1'b0;
        wb_gr_dest        = 5'd0;
        wb_gr_dest_sysreg = 1'b0;
        wb_gr_data        = 32'd0;
        wb_spr_valid      = 1'b0;
        wb_spr_data       = 32'd0;
        wb_frcr_valid     = 1'b0;
        wb_frcr_data      = 64'd0;
        src_imm           = '0;
        src_sysreg        = '0;
        src_pointer       = '0;
        src_data          = '0;
        src_spr           = 32'd0;
        src_psr           = 32'd0;
    endtask

    task automatic set_wb(input logic v, input logic [4:0] d, input logic s, input logic [31:0] data);
        wb_gr_valid       = v;
        wb_gr_dest        = d;
        wb_gr_dest_sysreg = s;
        wb_gr_data        = data;
    endtask

    task automatic set_src(input int k, input logic imm, input logic sys, input logic [4:0] ptr, input logic [31:0] data);
        src_imm[k]             = imm;
        src_sysreg[k]          = sys;
        src_pointer[k*5 +: 5]  = ptr;
        src_data[k*32 +: 32]   = data;
    endtask

    function automatic logic [4:0] pick_reg();
        case ($urandom_range(0, 7))
            0:       return 5'd1;
            1:       return 5'd2;
            2:       return 5'd3;
            3:       return `SYSREG_SPR;
            4:       return `SYSREG_PSR;
            5:       return `SYSREG_FRCLR;
            6:       return `SYSREG_FRCHR;
            default: return `SYSREG_FRCR2FRCXR;
        endcase
    endfunction

    // Random cycle stimulus, biased so that pointers collide often
    task automatic applyStimulus();
        rst               = ($urandom_range(0, 63) == 0);
        flush             = ($urandom_range(0, 15) == 0);
        hold              = ($urandom_range(0, 3) == 0);
        wb_gr_valid       = $urandom_range(0, 1) == 1;
        wb_gr_dest        = pick_reg();
        wb_gr_dest_sysreg = ($urandom_range(0, 2) == 0);
        wb_gr_data        = $urandom;
        wb_spr_valid      = ($urandom_range(0, 3) == 0);
        wb_spr_data       = $urandom;
`ifdef EXECUTE_FORWARDING_MULTI_FRCR_EN
        wb_frcr_valid     = ($urandom_range(0, 3) == 0);
        wb_frcr_data      = {$urandom, $urandom};
`endif
        for (int k = 0; k < P_NSRC; k++)
            set_src(k, $urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0, pick_reg(), $urandom);
        src_spr = $urandom;
        src_psr = $urandom;
        if (rst)
            model_q.delete();
    endtask

    task automatic compare_all();
        logic [32:0] r;
        logic [31:0] exp_data;
        logic        exp_hit;
        for (int k = 0; k < P_NSRC; k++) begin
            exp_data = src_data[k*32 +: 32];
            exp_hit  = 1'b0;
            if (!rst && !src_imm[k]) begin
                r = ref_resolve(src_sysreg[k], src_pointer[k*5 +: 5]);
                if (r[32]) begin
                    exp_hit  = 1'b1;
                    exp_data = r[31:0];
                end
            end
            checkOutput($sformatf("rand_op%0d_data", k), out_src_data[k*32 +: 32], exp_data);
            checkOutput($sformatf("rand_op%0d_hit", k), 32'(out_src_hit[k]), 32'(exp_hit));
        end
        exp_data = src_spr;
        if (!rst) begin
            r = ref_resolve(1'b1, `SYSREG_SPR);
            if (r[32])
                exp_data = r[31:0];
        end
        checkOutput("rand_spr", out_spr, exp_data);
        exp_data = src_psr;
        if (!rst) begin
            r = ref_resolve(1'b1, `SYSREG_PSR);
            if (r[32])
                exp_data = r[31:0];
        end
        checkOutput("rand_psr", out_psr, exp_data);
    endtask

    initial begin
        // Reset: everything passes straight through, even with a live writeback
        idle_inputs();
        rst = 1'b1;
        model_q.delete();
        set_wb(1'b1, 5'd3, 1'b0, 32'h1234);
        wb_spr_valid = 1'b1;
        wb_spr_data  = 32'h7777;
        set_src(0, 1'b0, 1'b0, 5'd3, 32'hCAFE);
        src_spr = 32'h5151;
        src_psr = 32'h6161;
        #2;
        checkOutput("rst_data", out_src_data[31:0], 32'hCAFE);
        checkOutput("rst_hit", 32'(out_src_hit), 32'd0);
        checkOutput("rst_spr", out_spr, 32'h5151);
        checkOutput("rst_psr", out_psr, 32'h6161);
        tick();
        tick();
        rst = 1'b0;
        idle_inputs();

        // Newest write to r3 wins, both operands see the same value
        set_wb(1'b1, 5'd3, 1'b0, 32'h11);
        tick();
        set_wb(1'b1, 5'd3, 1'b0, 32'h22);
        tick();
        idle_inputs();
        set_src(0, 1'b0, 1'b0, 5'd3, 32'h0);
        set_src(1, 1'b0, 1'b0, 5'd3, 32'h1);
        #2;
        checkOutput("newest_data", out_src_data[31:0], 32'h22);
        checkOutput("newest_hit", 32'(out_src_hit[0]), 32'd1);
        checkOutput("same_ptr_op1", out_src_data[63:32], 32'h22);
        tick();

        // Aging: visible in the oldest entry, gone one unheld cycle later
        set_wb(1'b1, 5'd5, 1'b0, 32'hA5);
        tick();
        idle_inputs();
        tick();
        set_src(0, 1'b0, 1'b0, 5'd5, 32'h99);
        #2;
        checkOutput("age_oldest_data", out_src_data[31:0], 32'hA5);
        tick();
        #2;
        checkOutput("age_out_data", out_src_data[31:0], 32'h99);
        checkOutput("age_out_hit", 32'(out_src_hit[0]), 32'd0);

        // Hold bubbles do not age the history
        idle_inputs();
        set_wb(1'b1, 5'd7, 1'b0, 32'h77);
        hold = 1'b1;
        tick();
        set_wb(1'b0, 5'd0, 1'b0, 32'h0);
        set_src(0, 1'b0, 1'b0, 5'd7, 32'h0);
        for (int i = 0; i < 5; i++) begin
            #2;
            checkOutput($sformatf("hold_data%0d", i), out_src_data[31:0], 32'h77);
            tick();
        end
        hold = 1'b0;

        // Live writeback beats an older entry for the same register
        idle_inputs();
        set_wb(1'b1, 5'd3, 1'b0, 32'h44);
        tick();
        set_wb(1'b1, 5'd3, 1'b0, 32'h55);
        set_src(0, 1'b0, 1'b0, 5'd3, 32'h0);
        #2;
        checkOutput("wb_wins", out_src_data[31:0], 32'h55);
        tick();

        // SPR write beats a GR write to SPR in the same level
        idle_inputs();
        set_wb(1'b1, `SYSREG_SPR, 1'b1, 32'h2000);
        wb_spr_valid = 1'b1;
        wb_spr_data  = 32'h1000;
        set_src(1, 1'b0, 1'b1, `SYSREG_SPR, 32'hEEEE);
        src_spr = 32'h3333;
        #2;
        checkOutput("spr_cur", out_spr, 32'h1000);
        checkOutput("spr_op_data", out_src_data[63:32], 32'h1000);
        checkOutput("spr_op_hit", 32'(out_src_hit[1]), 32'd1);
        tick();
        idle_inputs();
        hold    = 1'b1;
        src_spr = 32'h3333;
        #2;
        checkOutput("spr_hist", out_spr, 32'h1000);

        // PSR forwarding from live writeback and then from history
        hold = 1'b0;
        set_wb(1'b1, `SYSREG_PSR, 1'b1, 32'hABCD);
        src_psr = 32'h4444;
        #2;
        checkOutput("psr_cur", out_psr, 32'hABCD);
        tick();
        set_wb(1'b0, 5'd0, 1'b0, 32'h0);
        hold = 1'b1;
        #2;
        checkOutput("psr_hist", out_psr, 32'hABCD);

        // Immediate operands never forward
        idle_inputs();
        set_wb(1'b1, 5'd2, 1'b0, 32'h42);
        set_src(0, 1'b1, 1'b0, 5'd2, 32'h17);
        #2;
        checkOutput("imm_data", out_src_data[31:0], 32'h17);
        checkOutput("imm_hit", 32'(out_src_hit[0]), 32'd0);
        tick();

        // Flush drops history and does not insert the live writeback
        idle_inputs();
        set_wb(1'b1, 5'd1, 1'b0, 32'h5);
        tick();
        idle_inputs();
        hold = 1'b1;
        set_src(0, 1'b0, 1'b0, 5'd1, 32'hDEAD);
        #2;
        checkOutput("preflush_r1", out_src_data[31:0], 32'h5);
        hold  = 1'b0;
        flush = 1'b1;
        set_wb(1'b1, 5'd2, 1'b0, 32'h9);
        tick();
        idle_inputs();
        set_src(0, 1'b0, 1'b0, 5'd1, 32'hDEAD);
        set_src(1, 1'b0, 1'b0, 5'd2, 32'hBEEF);
        #2;
        checkOutput("flush_r1_data", out_src_data[31:0], 32'hDEAD);
        checkOutput("flush_r1_hit", 32'(out_src_hit[0]), 32'd0);
        checkOutput("flush_r2_data", out_src_data[63:32], 32'hBEEF);

        // Reset mid-cycle wipes history immediately
        idle_inputs();
        set_wb(1'b1, 5'd1, 1'b0, 32'h66);
        tick();
        set_wb(1'b1, 5'd2, 1'b0, 32'h67);
        #1;
        rst = 1'b1;
        model_q.delete();
        set_wb(1'b0, 5'd0, 1'b0, 32'h0);
        set_src(0, 1'b0, 1'b0, 5'd1, 32'h1111);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("midrst_data", out_src_data[31:0], 32'h1111);
        checkOutput("midrst_hit", 32'(out_src_hit[0]), 32'd0);
        tick();

`ifdef EXECUTE_FORWARDING_MULTI_FRCR_EN
        // FRCR halves forward through FRCHR/FRCLR
        idle_inputs();
        set_wb(1'b0, `SYSREG_FRCR2FRCXR, 1'b1, 32'h0);
        wb_frcr_valid = 1'b1;
        wb_frcr_data  = 64'h0000_0001_0000_0002;
        tick();
        idle_inputs();
        hold = 1'b1;
        set_src(0, 1'b0, 1'b1, `SYSREG_FRCHR, 32'h0);
        set_src(1, 1'b0, 1'b1, `SYSREG_FRCLR, 32'h0);
        #2;
        checkOutput("frchr", out_src_data[31:0], 32'h1);
        checkOutput("frclr", out_src_data[63:32], 32'h2);
        tick();
`endif

        // Randomized traffic against the queue model
        idle_inputs();
        rst = 1'b1;
        model_q.delete();
        tick();
        rst = 1'b0;
        for (int n = 0; n < 400; n++) begin
            applyStimulus();
            #2;
            compare_all();
            tick();
        end

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule

// File: doc/execute_forwarding_multi.md
EXECUTE_FORWARDING_MULTI -- requirements
Module: execute_forwarding_multi

Interface
REQ-001 SHALL have parameter P_DEPTH, default 2: number of registered writeback history entries, legal 1..8.
REQ-002 SHALL have parameter P_NSRC, default 2: number of source operands resolved in parallel, legal 1..4.
REQ-003 SHALL have ports: iCLOCK in 1, clock; iRESET in 1, asynchronous active-high reset.
REQ-004 SHALL have ports: iFLUSH in 1, synchronous clear of history; iHOLD in 1, pipeline stall.
REQ-005 SHALL have ports: iWB_GR_VALID in 1; iWB_GR_DEST in 5; iWB_GR_DEST_SYSREG in 1; iWB_GR_DATA in 32. These carry the current-cycle register writeback.
REQ-006 SHALL have ports: iWB_SPR_VALID in 1; iWB_SPR_DATA in 32. These carry the current-cycle stack pointer writeback.
REQ-007 SHALL have ports: iSRC_IMM in P_NSRC; iSRC_SYSREG in P_NSRC; iSRC_POINTER in 5*P_NSRC; iSRC_DATA in 32*P_NSRC. These are per-operand register-file values, with operand k in slice k.
REQ-008 SHALL have ports: iSRC_SPR in 32; iSRC_PSR in 32. These are the register-file SPR and PSR values.
REQ-009 SHALL have ports: oSRC_DATA out 32*P_NSRC; oSRC_HIT out P_NSRC; oSPR out 32; oPSR out 32.

Function
REQ-010 SHALL hold P_DEPTH history entries. Each entry stores {gr_valid, dest, sysreg, gr_data, spr_valid, spr_data}. Entry 0 is the newest.
REQ-011 SHALL shift the history on a clock edge when shift_en = !iHOLD | iWB_GR_VALID | iWB_SPR_VALID. On a shift, entry0 takes the current WB inputs and entry k takes entry k-1. The oldest entry is discarded.
REQ-012 SHALL leave the history unchanged when shift_en = 0. An iHOLD bubble therefore does not age older writes.
REQ-013 SHALL, on iFLUSH = 1, clear all gr_valid and spr_valid bits at the next edge. iFLUSH takes priority over the shift, and the current WB is not inserted.
REQ-014 SHALL resolve each operand combinationally with 0-cycle latency. Lookup priority is current WB, then entry0, then entry P_DEPTH-1, then iSRC_DATA.
REQ-015 SHALL match a GR level only when all hold: !imm, !src_sysreg, level gr_valid, !level sysreg, pointer == dest. The result is the level gr_data.
REQ-016 SHALL handle a sysreg source whose pointer is `SYSREG_SPR as follows. It matches a level with spr_valid, returning spr_data. It also matches a level with gr_valid & sysreg & dest == `SYSREG_SPR, returning gr_data. spr_valid wins within one level.
REQ-017 SHALL match other sysreg sources (not `SYSREG_SPR) only when all hold: !imm, level gr_valid, level sysreg, dest == pointer.
REQ-018 SHALL set oSRC_HIT[k] = 1 iff any level matched operand k. When oSRC_HIT[k] = 1, oSRC_DATA slice k is the forwarded value. When imm = 1, the slice equals iSRC_DATA and HIT = 0.
REQ-019 SHALL drive oSPR with the newest SPR match per REQ-016, else iSRC_SPR.
REQ-020 SHALL drive oPSR with the newest level matching sysreg dest `SYSREG_PSR, else iSRC_PSR.
REQ-021 SHALL keep operands independent. Identical pointers on two operands SHALL yield identical results.
REQ-022 SHALL, when the current WB and a history entry target the same register, return the current WB value.

Reset
REQ-023 SHALL, while iRESET = 1, asynchronously clear all valid bits and zero all entry data.
REQ-024 SHALL, during reset, pass iSRC_DATA, iSRC_SPR and iSRC_PSR through to the outputs, with oSRC_HIT = 0.
REQ-025 SHALL start shifting at the first edge after iRESET deasserts.

Configuration
REQ-026 SHALL support the macro EXECUTE_FORWARDING_MULTI_FRCR_EN.
REQ-027 SHALL, when EXECUTE_FORWARDING_MULTI_FRCR_EN is defined:
- add ports iWB_FRCR_VALID in 1 and iWB_FRCR_DATA in 64;
- store {frcr_valid, frcr_data} per entry;
- forward sysreg source `SYSREG_FRCLR from frcr_data[31:0];
- forward sysreg source `SYSREG_FRCHR from frcr_data[63:32];
- match FRCR levels only where frcr_valid & dest == `SYSREG_FRCR2FRCXR, with the same priority as GR;
- include iWB_FRCR_VALID in shift_en.
REQ-028 SHALL, when EXECUTE_FORWARDING_MULTI_FRCR_EN is undefined, omit the FRCR ports and storage, and resolve FRCLR/FRCHR per REQ-017 only.

Verification
REQ-029 SHALL cover GR newest-wins:
- stimulus: P_DEPTH=2; write r3=0x11, then r3=0x22; next cycle read r3 with iSRC_DATA=0x00;
- required response: oSRC_DATA=0x22, HIT=1.
REQ-030 SHALL cover history aging:
- stimulus: write r5=0xA5, then 2 idle unheld cycles;
- required response: reading r5 with iSRC_DATA=0x99 gives 0x99, HIT=0.
REQ-031 SHALL cover hold:
- stimulus: write r7=0x77; hold for 5 cycles;
- required response: a read of r7 returns 0x77 on every held cycle.
REQ-032 SHALL cover SPR same-level priority:
- stimulus: a level has spr_valid=1 with 0x1000 and gr sysreg SPR write 0x2000;
- required response: oSPR=0x1000.
REQ-033 SHALL cover flush and reset:
- stimulus: write r1=0x5; iFLUSH=1;
- required response: the next-cycle read returns iSRC_DATA. iRESET mid-shift clears all entries immediately.
REQ-034 SHALL cover FRCR (only with EXECUTE_FORWARDING_MULTI_FRCR_EN defined):
- stimulus: FRCR write 0x0000_0001_0000_0002, then read FRCHR;
- required response: FRCHR returns 0x1, and FRCLR returns 0x2.
